// File: rtl/digit_rev_addr_gen.sv
// Purpose: self-sequencing NTT reorder index stream; counts seq 0..2^(RADIX_K*l)-1 and emits its bit (or digit) reversal.
// Latency: start accepted at cycle T gives the first beat (seq=0) at T+1; one beat per cycle while out_ready is high.
// Backpressure: out_ready low holds out_idx/out_seq/out_last stable; no combinational path from out_ready to outputs.
// Build option: define BITREV_DIGIT_EN to reverse RADIX_K-bit digits instead of single bits.
module digit_rev_addr_gen #(
    parameter int D_WIDTH = 12,
    parameter int RADIX_K = 3,
    parameter int L_WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               clear,
    input  logic [L_WIDTH-1:0] l,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] out_idx,
    output logic [D_WIDTH-1:0] out_seq,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [5:0]         w_q, w_d;
    logic [5:0]         w_calc;
    logic [D_WIDTH-1:0] seq_d, idx_d, seq_inc, idx_inc;
    logic [D_WIDTH:0]   last_seq;
    logic               last_d, last_inc, cfg_err_d;

    // Reversed-index width for the requested stage count (max 3*7 = 21 fits 6 bits).
    assign w_calc  = 6'(RADIX_K) * 6'(l);
    assign seq_inc = out_seq + 1'b1;
    // N-1 for the active run, one bit wider so W = D_WIDTH needs no special case.
    assign last_seq = ({{D_WIDTH{1'b0}}, 1'b1} << w_q) - 1'b1;
    assign last_inc = ({1'b0, seq_inc} == last_seq);

`ifdef BITREV_DIGIT_EN
    localparam int MAXD = (D_WIDTH + RADIX_K - 1) / RADIX_K;

    logic [L_WIDTH-1:0] l_q, l_d;

    // Digit j of s lands at digit position lv-1-j; bit order within a digit is kept.
    function automatic logic [D_WIDTH-1:0] rev_idx(input logic [D_WIDTH-1:0] s,
                                                   input logic [L_WIDTH-1:0] lv);
        logic [D_WIDTH-1:0] r;
        r = '0;
        for (int j = 0; j < MAXD; j++) begin
            for (int p = 0; p < MAXD; p++) begin
                if ((j < int'(lv)) && (j + p == int'(lv) - 1)) begin
                    for (int b = 0; b < RADIX_K; b++) begin
                        if ((RADIX_K * j + b < D_WIDTH) && (RADIX_K * p + b < D_WIDTH))
                            r[RADIX_K * p + b] = s[RADIX_K * j + b];
                    end
                end
            end
        end
        return r;
    endfunction

    assign idx_inc = rev_idx(seq_inc, l_q);
`else
    // Bit i of s lands at bit w-1-i; bits at or above w stay zero.
    function automatic logic [D_WIDTH-1:0] rev_idx(input logic [D_WIDTH-1:0] s,
                                                   input logic [5:0] w);
        logic [D_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < D_WIDTH; i++) begin
            for (int j = 0; j < D_WIDTH; j++) begin
                if ((i < int'(w)) && (i + j == int'(w) - 1))
                    r[j] = s[i];
            end
        end
        return r;
    endfunction

    assign idx_inc = rev_idx(seq_inc, w_q);
`endif

    // Next-state and next-output decode; clear overrides every transition.
    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        seq_d     = out_seq;
        idx_d     = out_idx;
        last_d    = out_last;
        cfg_err_d = 1'b0;
`ifdef BITREV_DIGIT_EN
        l_d       = l_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (int'(w_calc) > D_WIDTH) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        w_d     = w_calc;
                        seq_d   = '0;
                        idx_d   = '0;
                        last_d  = (w_calc == 6'd0);
`ifdef BITREV_DIGIT_EN
                        l_d     = l;
`endif
                    end
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (out_last) begin
                        state_d = DONE;
                        last_d  = 1'b0;
                    end else begin
                        seq_d  = seq_inc;
                        idx_d  = idx_inc;
                        last_d = last_inc;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (clear) begin
            state_d   = IDLE;
            last_d    = 1'b0;
            cfg_err_d = 1'b0;
        end
    end

    // State, index and status registers; status flags are registered decodes of the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            w_q       <= '0;
            out_seq   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
`ifdef BITREV_DIGIT_EN
            l_q       <= '0;
`endif
        end else begin
            state_q   <= state_d;
            w_q       <= w_d;
            out_seq   <= seq_d;
            out_idx   <= idx_d;
            out_last  <= last_d;
            out_valid <= (state_d == RUN);
            busy      <= (state_d == RUN);
            done      <= (state_d == DONE);
            cfg_err   <= cfg_err_d;
`ifdef BITREV_DIGIT_EN
            l_q       <= l_d;
`endif
        end
    end

endmodule
